// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the single-port SRAM responder.
package sram_resp_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Bit value replicated across read-data registers on reset
  localparam logic RD_RST_BIT = 1'b0;

  // Counter index map for the statistics bank
  localparam int CNT_RD   = 0;
  localparam int CNT_WR   = 1;
  localparam int CNT_CONF = 2;
  localparam int NUM_CNT  = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (inc && ~&cnt)    cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/sram_sp_responder.sv
// Single-port SRAM responder: engine port with priority, host back-door,
// self-clearing array after reset, and saturating access statistics.
module sram_sp_responder
  import sram_resp_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 9,
  parameter int DEPTH = 512,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce_n,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic          ready,
  output logic          err,
  output logic [CW-1:0] rd_cnt,
  output logic [CW-1:0] wr_cnt,
  output logic [CW-1:0] conflict_cnt
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH-1);

  state_t              state, state_nxt;
  logic [AW-1:0]       clr_ptr;
  logic [DW-1:0]       mem [DEPTH];
  logic                eng_acc, eng_ok, h_ok, h_rd;
  logic [NUM_CNT-1:0]  inc;
  logic [NUM_CNT-1:0][CW-1:0] cnt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  // Next-state logic: sweep finishes after the last word is zeroed
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_ptr == LAST) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  // Output / qualifier logic; engine always wins, host only on idle engine
  always_comb begin
    ready   = (state == READY);
    eng_acc = ready && !ce_n;
    eng_ok  = {1'b0, addr}   < DEPTH_V;
    h_ok    = {1'b0, h_addr} < DEPTH_V;
    h_gnt   = !rst && ready && h_req && ce_n;
    h_rd    = h_gnt && !h_we;
  end

  always_ff @(posedge clk) begin
    if (rst)                  clr_ptr <= '0;
    else if (state == CLEAR)  clr_ptr <= clr_ptr + AW'(1);
  end

  // Array: no reset on storage, the clear sweep initialises it
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)                mem[clr_ptr] <= '0;
      else if (eng_acc && we && eng_ok)  mem[addr]    <= wdata;
      else if (h_gnt && h_we && h_ok)    mem[h_addr]  <= h_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata    <= {DW{RD_RST_BIT}};
      h_rdata  <= {DW{RD_RST_BIT}};
      h_rvalid <= 1'b0;
    end else begin
      h_rvalid <= h_rd;
      if (eng_acc && !we) rdata   <= eng_ok ? mem[addr]   : '0;
      if (h_rd)           h_rdata <= h_ok   ? mem[h_addr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if ((!ce_n && !ready) || (eng_acc && !eng_ok) || (h_gnt && !h_ok))
      err <= 1'b1;
  end

  always_comb begin
    inc           = '0;
    inc[CNT_RD]   = eng_acc && !we;
    inc[CNT_WR]   = eng_acc && we;
    inc[CNT_CONF] = ready && h_req && !ce_n;
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    sat_counter #(.CW(CW)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (inc[i]),
      .cnt (cnt[i])
    );
  end

  assign rd_cnt       = cnt[CNT_RD];
  assign wr_cnt       = cnt[CNT_WR];
  assign conflict_cnt = cnt[CNT_CONF];

endmodule

// File: tb/tb_sram_sp_responder.sv
// Scoreboard bench: full-depth DUT plus a DEPTH=300 DUT sharing stimulus.
module tb_sram_sp_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_n = 1'b1, we = 1'b0, h_req = 1'b0, h_we = 1'b0;
  logic [8:0]  addr = '0, h_addr = '0;
  logic [15:0] wdata = '0, h_wdata = '0;

  logic [15:0] rdata, h_rdata, rd_cnt, wr_cnt, conflict_cnt;
  logic        h_gnt, h_rvalid, ready, err;
  logic [15:0] rdata_s, h_rdata_s, rd_cnt_s, wr_cnt_s, conflict_cnt_s;
  logic        h_gnt_s, h_rvalid_s, ready_s, err_s;

  int errors = 0, checks = 0;
  logic rd_chk = 1'b0;

  typedef struct { logic [15:0] e; logic [15:0] es; } rd_exp_t;
  rd_exp_t     eq[$];
  logic [15:0] hq[$];

  always #5 clk = ~clk;

  sram_sp_responder #(.DW(16), .AW(9), .DEPTH(512), .CW(16)) dut (
    .clk(clk), .rst(rst), .ce_n(ce_n), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .h_req(h_req), .h_we(h_we), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .ready(ready), .err(err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
    .conflict_cnt(conflict_cnt));

  sram_sp_responder #(.DW(16), .AW(9), .DEPTH(300), .CW(16)) dut_s (
    .clk(clk), .rst(rst), .ce_n(ce_n), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_s), .h_req(h_req), .h_we(h_we), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_gnt(h_gnt_s), .h_rvalid(h_rvalid_s),
    .h_rdata(h_rdata_s), .ready(ready_s), .err(err_s), .rd_cnt(rd_cnt_s),
    .wr_cnt(wr_cnt_s), .conflict_cnt(conflict_cnt_s));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: engine reads flagged by stimulus compare the cycle after;
  // every h_rvalid pulse consumes one host expectation.
  initial begin
    logic f;
    rd_exp_t x;
    forever begin
      @(posedge clk);
      f = rd_chk;
      @(negedge clk);
      if (f) begin
        if (eq.size() == 0) chk("eng_rd_unexpected", 1, 0);
        else begin
          x = eq.pop_front();
          chk("eng_rdata", rdata, x.e);
          chk("eng_rdata_d300", rdata_s, x.es);
        end
      end
      if (h_rvalid) begin
        if (hq.size() == 0) chk("h_rvalid_spurious", 1, 0);
        else chk("h_rdata", h_rdata, hq.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic eng_wr(input logic [8:0] a, input logic [15:0] d);
    ce_n = 1'b0; we = 1'b1; addr = a; wdata = d;
    cyc();
    ce_n = 1'b1; we = 1'b0;
  endtask

  task automatic eng_rd(input logic [8:0] a, input logic [15:0] e, input logic [15:0] es);
    rd_exp_t x;
    x.e = e; x.es = es;
    eq.push_back(x);
    ce_n = 1'b0; we = 1'b0; addr = a; rd_chk = 1'b1;
    cyc();
    ce_n = 1'b1; rd_chk = 1'b0;
  endtask

  task automatic wait_ready(output int n, output int n_s);
    n = 0; n_s = 0;
    for (int i = 1; i <= 600; i++) begin
      cyc();
      if (ready_s && n_s == 0) n_s = i;
      if (ready) begin n = i; break; end
    end
    if (n == 0) chk("ready_timeout", 0, 1);
  endtask

  initial begin
    int n, n_s;
    repeat (3) cyc();
    chk("rst_rdata", rdata, 0);
    chk("rst_ready", ready, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_h_rvalid", h_rvalid, 0);
    chk("rst_h_gnt", h_gnt, 0);

    // 1: clear sweep length, then read a cleared word
    rst = 1'b0;
    wait_ready(n, n_s);
    chk("ready_latency", n, 512);
    chk("ready_latency_d300", n_s, 300);
    eng_rd(9'd0, 16'h0000, 16'h0000);
    chk("err_after_clear", err, 0);

    // 2: write then read-after-write
    eng_wr(9'd5, 16'h8001);
    eng_rd(9'd5, 16'h8001, 16'h8001);
    chk("wr_cnt_t2", wr_cnt, 1);
    chk("rd_cnt_t2", rd_cnt, 2);   // includes the read of test 1

    // 3: host write stalled by 3 engine reads, then granted
    h_req = 1'b1; h_we = 1'b1; h_addr = 9'd7; h_wdata = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      rd_exp_t x;
      x.e = 16'h0; x.es = 16'h0;
      eq.push_back(x);
      ce_n = 1'b0; we = 1'b0; addr = 9'd0; rd_chk = 1'b1;
      #1 chk("h_gnt_stalled", h_gnt, 0);
      cyc();
    end
    ce_n = 1'b1; rd_chk = 1'b0;
    #1 chk("h_gnt_idle", h_gnt, 1);
    cyc();
    h_req = 1'b0;
    chk("conflict_cnt", conflict_cnt, 3);
    chk("rd_cnt_t3", rd_cnt, 5);
    hq.push_back(16'h1234);
    h_req = 1'b1; h_we = 1'b0; h_addr = 9'd7;
    #1 chk("h_gnt_read", h_gnt, 1);
    cyc();
    h_req = 1'b0;
    cyc();

    // 4: address 310 is out of range only for the DEPTH=300 instance
    eng_wr(9'd310, 16'hFFFF);
    eng_rd(9'd310, 16'hFFFF, 16'h0000);
    chk("err_oor_d300", err_s, 1);
    chk("err_inrange_d512", err, 0);
    chk("rd_cnt_oor_d300", rd_cnt_s, 6);
    chk("wr_cnt_oor_d300", wr_cnt_s, 2);
    eng_rd(9'd54, 16'h0000, 16'h0000);
    chk("err_sticky_d300", err_s, 1);

    // 5: engine write during the clear sweep is ignored
    rst = 1'b1; cyc(); rst = 1'b0;
    repeat (9) cyc();
    eng_wr(9'd20, 16'hBEEF);
    chk("err_clear_access", err, 1);
    chk("wr_cnt_clear_access", wr_cnt, 0);
    wait_ready(n, n_s);
    eng_rd(9'd20, 16'h0000, 16'h0000);

    // 6: reset during a host read, array swept again
    h_req = 1'b1; h_we = 1'b1; h_addr = 9'd3; h_wdata = 16'hAAAA;
    #1 chk("h_gnt_preload", h_gnt, 1);
    cyc();
    h_req = 1'b0;
    eng_rd(9'd3, 16'hAAAA, 16'hAAAA);
    h_req = 1'b1; h_we = 1'b0; h_addr = 9'd3; rst = 1'b1;
    cyc();
    rst = 1'b0; h_req = 1'b0;
    chk("rst_h_rvalid_mid", h_rvalid, 0);
    chk("rst_rd_cnt_mid", rd_cnt, 0);
    chk("rst_conflict_mid", conflict_cnt, 0);
    chk("rst_ready_mid", ready, 0);
    chk("rst_err_mid", err, 0);
    wait_ready(n, n_s);
    chk("ready_latency_2", n, 512);
    eng_rd(9'd3, 16'h0000, 16'h0000);

    repeat (3) cyc();
    chk("eng_queue_drained", eq.size(), 0);
    chk("host_queue_drained", hq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
